// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub : digit-serial adder / subtractor
//
// Adds (A+B+CIN) or subtracts (A-B) two WIDTH-bit operands DIGIT bits per
// clock, LSB slice first. A single result register set (SUM/CARRY/OVF/ZERO)
// is updated once per operation together with a one-cycle DONE pulse.
//
// Parameters
//   WIDTH  operand / result width (>= 2)
//   DIGIT  bits processed per clock (must divide WIDTH)
// Ports
//   CLK    rising-edge clock
//   RST    synchronous active-high reset
//   START  start request (ignored while busy)
//   SUB    0 = add, 1 = subtract (captured with START)
//   CIN    carry-in for add, ignored for subtract (captured with START)
//   A, B   operands (captured with START)
//   SUM    registered result
//   CARRY  carry out of the MSB (subtract: 1 = no borrow)
//   OVF    two's-complement overflow
//   ZERO   result equals zero
//   BUSY   high during the N slice cycles
//   DONE   one-cycle pulse with each new result
// -----------------------------------------------------------------------------
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SUB,
   input  logic             CIN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] SUM,
   output logic             CARRY,
   output logic             OVF,
   output logic             ZERO,
   output logic             BUSY,
   output logic             DONE
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
         $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr, b_sr, acc;
   logic             carry_r;   // carry into the next slice
   logic             cmsb_r;    // carry into the top bit of the last slice
   logic [CW-1:0]    cnt;

   logic [DIGIT-1:0] s;
   logic [DIGIT:0]   c;
   logic [WIDTH-1:0] s_ext;
   logic [WIDTH-1:0] b_ld;
   logic             c_ld;

   // subtract is A + ~B + 1, so the operand is inverted at load time and the
   // initial carry forced to 1
   assign b_ld = SUB ? ~B : B;
   assign c_ld = SUB | CIN;

   // DIGIT-bit ripple over the current low slice
   always_comb begin
      s    = '0;
      c    = '0;
      c[0] = carry_r;
      for (int i = 0; i < DIGIT; i++) begin
         s[i]   = a_sr[i] ^ b_sr[i] ^ c[i];
         c[i+1] = (a_sr[i] & b_sr[i]) | (c[i] & (a_sr[i] ^ b_sr[i]));
      end
      s_ext            = '0;
      s_ext[DIGIT-1:0] = s;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         a_sr    <= '0;
         b_sr    <= '0;
         acc     <= '0;
         carry_r <= 1'b0;
         cmsb_r  <= 1'b0;
         SUM     <= '0;
         CARRY   <= 1'b0;
         OVF     <= 1'b0;
         ZERO    <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  a_sr    <= A;
                  b_sr    <= b_ld;
                  carry_r <= c_ld;
                  cnt     <= '0;
                  BUSY    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               a_sr    <= a_sr >> DIGIT;
               b_sr    <= b_sr >> DIGIT;
               // result slices enter from the top so the LSB slice ends up at bit 0
               acc     <= (acc >> DIGIT) | (s_ext << (WIDTH - DIGIT));
               carry_r <= c[DIGIT];
               cmsb_r  <= c[DIGIT-1];
               if (cnt == CW'(N - 1)) begin
                  BUSY  <= 1'b0;
                  state <= FIN;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            FIN: begin
               SUM   <= acc;
               CARRY <= carry_r;
               OVF   <= carry_r ^ cmsb_r;
               ZERO  <= (acc == '0);
               DONE  <= 1'b1;
               // back-to-back: acc is read above before the new run refills it
               if (START) begin
                  a_sr    <= A;
                  b_sr    <= b_ld;
                  carry_r <= c_ld;
                  cnt     <= '0;
                  BUSY    <= 1'b1;
                  state   <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub : self-checking bench for serial_addsub
//
// Four instances share one stimulus stream: 8/1, 8/4, 4/1 and 4/2
// (WIDTH/DIGIT). The 4-bit instances see the low nibble of A and B.
// Results are compared against an integer-arithmetic add/subtract model.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

   logic       CLK = 1'b0;
   logic       RST, START, SUB, CIN;
   logic [7:0] A, B;

   logic [7:0] sum0, sum1;
   logic [3:0] sum2, sum3;
   logic [3:0] co, ov, zr, bs, dn;

   int checks   = 0;
   int failures = 0;

   int wd [4] = '{8, 8, 4, 4};
   int lat[4] = '{9, 3, 5, 3};

   always #5 CLK = ~CLK;

   serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d0 (
      .CLK(CLK), .RST(RST), .START(START), .SUB(SUB), .CIN(CIN), .A(A), .B(B),
      .SUM(sum0), .CARRY(co[0]), .OVF(ov[0]), .ZERO(zr[0]), .BUSY(bs[0]), .DONE(dn[0]));
   serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d1 (
      .CLK(CLK), .RST(RST), .START(START), .SUB(SUB), .CIN(CIN), .A(A), .B(B),
      .SUM(sum1), .CARRY(co[1]), .OVF(ov[1]), .ZERO(zr[1]), .BUSY(bs[1]), .DONE(dn[1]));
   serial_addsub #(.WIDTH(4), .DIGIT(1)) u_d2 (
      .CLK(CLK), .RST(RST), .START(START), .SUB(SUB), .CIN(CIN), .A(A[3:0]), .B(B[3:0]),
      .SUM(sum2), .CARRY(co[2]), .OVF(ov[2]), .ZERO(zr[2]), .BUSY(bs[2]), .DONE(dn[2]));
   serial_addsub #(.WIDTH(4), .DIGIT(2)) u_d3 (
      .CLK(CLK), .RST(RST), .START(START), .SUB(SUB), .CIN(CIN), .A(A[3:0]), .B(B[3:0]),
      .SUM(sum3), .CARRY(co[3]), .OVF(ov[3]), .ZERO(zr[3]), .BUSY(bs[3]), .DONE(dn[3]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [7:0] sumv(input int d);
      case (d)
         0:       return sum0;
         1:       return sum1;
         2:       return {4'h0, sum2};
         default: return {4'h0, sum3};
      endcase
   endfunction

   // {ZERO, OVF, CARRY, SUM}
   function automatic logic [10:0] obs(input int d);
      return {zr[d], ov[d], co[d], sumv(d)};
   endfunction

   // reference: plain integer arithmetic on the w-bit operands
   function automatic logic [10:0] model(input int w, input bit sub, input bit cin,
                                         input logic [7:0] a, input logic [7:0] b);
      int m, half, aa, bb, c, full, sa, sb, st;
      logic [7:0] s;
      m    = (1 << w) - 1;
      half = 1 << (w - 1);
      aa   = int'(a) & m;
      bb   = sub ? ((~int'(b)) & m) : (int'(b) & m);
      c    = sub ? 1 : int'(cin);
      full = aa + bb + c;
      s    = 8'(full & m);
      sa   = (aa >= half) ? aa - (1 << w) : aa;
      sb   = (bb >= half) ? bb - (1 << w) : bb;
      st   = sa + sb + c;
      return {s == 8'h00, (st >= half) || (st < -half), ((full >> w) & 1) == 1, s};
   endfunction

   // one operation on all instances; checks latency, single DONE, result
   task automatic run_op(input bit sub, input bit cin, input logic [7:0] a,
                         input logic [7:0] b, input string tag);
      int         first[4];
      int         ndone[4];
      logic [10:0] got[4];
      int         busy0;
      logic [7:0] prev0;
      logic [7:0] r;
      busy0 = 0;
      prev0 = sum0;
      for (int d = 0; d < 4; d++) begin
         first[d] = -1;
         ndone[d] = 0;
         got[d]   = '0;
      end
      START = 1'b1; SUB = sub; CIN = cin; A = a; B = b;
      tick();
      // scramble inputs to prove they were captured
      START = 1'b0;
      r = 8'($urandom); A = r;
      r = 8'($urandom); B = r;
      SUB = 1'($urandom); CIN = 1'($urandom);
      for (int off = 0; off < 13; off++) begin
         for (int d = 0; d < 4; d++) begin
            if (dn[d]) begin
               ndone[d]++;
               if (first[d] < 0) begin
                  first[d] = off;
                  got[d]   = obs(d);
               end
            end
         end
         if (bs[0]) busy0++;
         if (off == 4) chk({tag, "_hold"}, sum0, prev0);
         tick();
      end
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("%s_lat%0d", tag, d), first[d], lat[d]);
         chk($sformatf("%s_ndone%0d", tag, d), ndone[d], 1);
         chk($sformatf("%s_res%0d", tag, d), got[d], model(wd[d], sub, cin, a, b));
      end
      chk({tag, "_busy"}, busy0, 8);
   endtask

   initial begin
      int         first, ndone, dlist[$];
      logic [10:0] res[$];
      logic [7:0] ra, rb;

      RST = 1'b1; START = 1'b1; SUB = 1'b0; CIN = 1'b0; A = 8'h12; B = 8'h34;
      tick();
      tick();
      // reset wins over START
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("rst_out%0d", d), {obs(d), bs[d], dn[d]}, 0);
      end
      RST = 1'b0; START = 1'b0;
      tick();

      // directed vectors
      run_op(0, 0, 8'h3C, 8'h42, "add_3c_42");
      chk("add_3c_42_exp", obs(0), {1'b0, 1'b0, 1'b0, 8'h7E});
      run_op(0, 0, 8'hFF, 8'h01, "add_ff_01");
      chk("add_ff_01_exp", obs(0), {1'b1, 1'b0, 1'b1, 8'h00});
      run_op(0, 1, 8'h7F, 8'h00, "add_7f_cin");
      chk("add_7f_cin_exp", obs(0), {1'b0, 1'b1, 1'b0, 8'h80});
      run_op(1, 1, 8'h05, 8'h07, "sub_05_07");
      chk("sub_05_07_exp", obs(0), {1'b0, 1'b0, 1'b0, 8'hFE});
      run_op(1, 0, 8'h80, 8'h01, "sub_80_01");
      chk("sub_80_01_exp", obs(0), {1'b0, 1'b1, 1'b1, 8'h7F});
      run_op(1, 0, 8'h33, 8'h33, "sub_33_33");
      chk("sub_33_33_exp", obs(0), {1'b1, 1'b0, 1'b1, 8'h00});

      // START mid-RUN with other operands must be ignored (8/1 instance)
      first = -1; ndone = 0;
      START = 1'b1; SUB = 1'b0; CIN = 1'b0; A = 8'h10; B = 8'h20;
      tick();
      START = 1'b0;
      for (int off = 0; off < 13; off++) begin
         if (dn[0]) begin
            ndone++;
            if (first < 0) first = off;
         end
         if (off == 3) begin START = 1'b1; A = 8'hAA; B = 8'h55; SUB = 1'b1; end
         else          begin START = 1'b0; SUB = 1'b0; end
         tick();
      end
      chk("mid_start_lat", first, 9);
      chk("mid_start_ndone", ndone, 1);
      chk("mid_start_res", obs(0), model(8, 0, 0, 8'h10, 8'h20));
      repeat (10) tick();

      // START held through FIN: second op starts with no idle cycle
      dlist.delete(); res.delete();
      START = 1'b1; SUB = 1'b0; CIN = 1'b0; A = 8'h12; B = 8'h34;
      tick();
      A = 8'h70; B = 8'h10;
      for (int off = 0; off < 21; off++) begin
         if (dn[0]) begin
            dlist.push_back(off);
            res.push_back(obs(0));
         end
         if (off == 9) begin
            chk("b2b_busy_fin", bs[0], 1'b1);
            START = 1'b0;
         end
         tick();
      end
      chk("b2b_ndone", dlist.size(), 2);
      if (dlist.size() == 2) begin
         chk("b2b_lat1", dlist[0], 9);
         chk("b2b_lat2", dlist[1], 18);
         chk("b2b_res1", res[0], model(8, 0, 0, 8'h12, 8'h34));
         chk("b2b_res2", res[1], model(8, 0, 0, 8'h70, 8'h10));
      end
      repeat (10) tick();

      // make the held result non-zero, then abort mid-RUN with reset
      run_op(0, 0, 8'h3C, 8'h42, "pre_rst");
      START = 1'b1; SUB = 1'b0; CIN = 1'b0; A = 8'h55; B = 8'h0F;
      tick();
      START = 1'b0;
      tick(); tick(); tick();   // now in the 4th RUN cycle
      RST = 1'b1;
      tick();
      chk("abort_out", {obs(0), bs[0], dn[0]}, 0);
      RST = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (dn[0]) ndone++;
         tick();
      end
      chk("abort_no_done", ndone, 0);
      run_op(0, 0, 8'h01, 8'h01, "after_rst");
      chk("after_rst_exp", sum0, 8'h02);

      // exhaustive over the 4-bit operand space (upper nibble random)
      for (int sb = 0; sb < 2; sb++) begin
         for (int ci = 0; ci < 2; ci++) begin
            for (int a = 0; a < 16; a++) begin
               for (int b = 0; b < 16; b++) begin
                  ra = 8'($urandom); rb = 8'($urandom);
                  run_op(sb[0], ci[0], {ra[7:4], 4'(a)}, {rb[7:4], 4'(b)}, "exh");
               end
            end
         end
      end

      // random full-width operands
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         run_op(1'($urandom), 1'($urandom), ra, rb, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
